count_bits_pipe: RTL and testbench

COUNT_BITS_PIPE -- requirements
Module: count_bits_pipe

---
 rtl/count_bits_pkg.sv | 35 +++
 rtl/count_bits_csa.sv | 37 +++
 rtl/count_bits_pipe.sv | 132 +++++++++++++
 tb/tb_count_bits_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_bits_pkg.sv
// Shared types and helpers for the count_bits pipeline: mode encoding,
// per-nibble population count and the 3:2 carry-save compressor.
package count_bits_pkg;

  typedef enum logic [1:0] {
    MODE_ZEROS = 2'b00,
    MODE_ONES  = 2'b01,
    MODE_LZ    = 2'b10,
    MODE_TZ    = 2'b11
  } mode_e;

  // Wide enough for a count of up to 256; modules truncate to their own width.
  localparam int CNT_W = 9;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t s;
    cnt_t c;
  } csa_t;

  // Number of set bits in a nibble (0..4).
  function automatic logic [2:0] nib_cnt(input logic [3:0] n);
    return {2'b00, n[0]} + {2'b00, n[1]} + {2'b00, n[2]} + {2'b00, n[3]};
  endfunction

  // 3:2 compressor: a + b + c == s + c_out. The operands always sum to at
  // most 256, so the shifted-out majority bit is always zero.
  function automatic csa_t csa32(input cnt_t a, input cnt_t b, input cnt_t c);
    csa_t r;
    r.s = a ^ b ^ c;
    r.c = ((a & b) | (a & c) | (b & c)) << 1;
    return r;
  endfunction

endpackage

// File: rtl/count_bits_csa.sv
// Combinational popcount front end: per-nibble counts reduced by a tree of
// 3:2 compressors down to one sum/carry pair. Counts ones, or zeros when
// ones=0.
module count_bits_csa
  import count_bits_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]       x,
  input  logic               ones,
  output logic [$clog2(W):0] sum,
  output logic [$clog2(W):0] carry
);

  localparam int YW    = $clog2(W) + 1;
  localparam int NIB   = W / 4;
  // Each compressor consumes three nodes and appends two, FIFO order, so the
  // tree has NIB-2 compressors and the final pair lands in the last two nodes.
  localparam int NODES = 3 * NIB - 4;

  logic [W-1:0] xv;
  cnt_t         node [NODES];

  assign xv = ones ? x : ~x;

  // Leaf counts then breadth-first compression.
  always_comb begin
    for (int i = 0; i < NODES; i++) node[i] = '0;
    for (int i = 0; i < NIB; i++) node[i] = cnt_t'(nib_cnt(xv[4*i +: 4]));
    for (int k = 0; k < NIB - 2; k++)
      {node[NIB+2*k], node[NIB+2*k+1]} = csa32(node[3*k], node[3*k+1], node[3*k+2]);
  end

  assign sum   = node[NODES-2][YW-1:0];
  assign carry = node[NODES-1][YW-1:0];

endmodule

// File: rtl/count_bits_pipe.sv
// Two-stage bit-count pipeline with valid/ready flow control.
// S1 holds the carry-save pair (or the leading/trailing-zero count with a
// zero carry), S2 holds the resolved count. Optional saturating accumulator
// of delivered results is enabled by defining COUNT_BITS_PIPE_ACC_EN.
module count_bits_pipe
  import count_bits_pkg::*;
#(
  parameter int W     = 32,
  parameter int ACC_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       x,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [$clog2(W):0] y,
  output logic [1:0]         y_mode
`ifdef COUNT_BITS_PIPE_ACC_EN
  ,
  input  logic               acc_clr,
  output logic [ACC_W-1:0]   acc_r
`endif
);

  localparam int YW = $clog2(W) + 1;
  typedef logic [YW-1:0] ycnt_t;

  logic         s1_v_q, s2_v_q;
  logic         s1_adv, s2_adv;
  ycnt_t        csa_sum, csa_carry, tz_cnt;
  ycnt_t        s1_sum_d, s1_carry_d, s1_sum_q, s1_carry_q;
  ycnt_t        y_d, y_q;
  mode_e        s1_mode_q, y_mode_q;
  logic [W-1:0] xs;

  // A stage moves when it is empty or the stage after it moves.
  assign s2_adv   = !s2_v_q || out_ready;
  assign s1_adv   = !s1_v_q || s2_adv;
  assign in_ready = s1_adv;

  count_bits_csa #(.W(W)) u_csa (
    .x     (x),
    .ones  (mode == MODE_ONES),
    .sum   (csa_sum),
    .carry (csa_carry)
  );

  // Leading zeros are trailing zeros of the bit-reversed word; all-zero gives W.
  always_comb begin
    xs = x;
    if (mode == MODE_LZ)
      for (int i = 0; i < W; i++) xs[i] = x[W-1-i];
    tz_cnt = ycnt_t'(W);
    for (int i = W - 1; i >= 0; i--)
      if (xs[i]) tz_cnt = ycnt_t'(i);
  end

  // S1 payload: popcount modes keep the carry-save pair, zero-run modes the count.
  always_comb begin
    s1_sum_d   = csa_sum;
    s1_carry_d = csa_carry;
    if (mode[1]) begin
      s1_sum_d   = tz_cnt;
      s1_carry_d = '0;
    end
  end

  // Final add never overflows: sum + carry is at most W.
  assign y_d = s1_sum_q + s1_carry_q;

  // S1 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q     <= 1'b0;
      s1_sum_q   <= '0;
      s1_carry_q <= '0;
      s1_mode_q  <= MODE_ZEROS;
    end else if (s1_adv) begin
      s1_v_q <= in_valid;
      if (in_valid) begin
        s1_sum_q   <= s1_sum_d;
        s1_carry_q <= s1_carry_d;
        s1_mode_q  <= mode_e'(mode);
      end
    end
  end

  // S2 register; holds its payload while stalled by the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q   <= 1'b0;
      y_q      <= '0;
      y_mode_q <= MODE_ZEROS;
    end else if (s2_adv) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        y_q      <= y_d;
        y_mode_q <= s1_mode_q;
      end
    end
  end

  assign out_valid = s2_v_q;
  assign y         = y_q;
  assign y_mode    = y_mode_q;

`ifdef COUNT_BITS_PIPE_ACC_EN
  localparam int SUM_W = ACC_W + YW + 1;
  logic [ACC_W-1:0] acc_q;
  logic [SUM_W-1:0] acc_sum;

  assign acc_sum = SUM_W'(acc_q) + SUM_W'(y_q);

  // Saturating running sum of delivered results; clear wins over a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc_q <= '0;
    else if (acc_clr)
      acc_q <= '0;
    else if (s2_v_q && out_ready)
      acc_q <= (|acc_sum[SUM_W-1:ACC_W]) ? '1 : acc_sum[ACC_W-1:0];
  end

  assign acc_r = acc_q;
`else
  // Accumulator not built.
`endif

endmodule

// File: tb/tb_count_bits_pipe.sv
// Self-checking bench for count_bits_pipe: directed W=32 sequences plus
// random traffic on W=8 and W=256 instances, scoreboarded in order.
module tb_count_bits_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int y; int m; } exp_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference bit counter.
  function automatic int ref_cnt(input logic [255:0] v, input int w, input int m);
    int c = 0;
    case (m)
      0: for (int i = 0; i < w; i++) c += int'(!v[i]);
      1: for (int i = 0; i < w; i++) c += int'(v[i]);
      2: for (int i = w - 1; i >= 0; i--) begin if (v[i]) break; c++; end
      default: for (int i = 0; i < w; i++) begin if (v[i]) break; c++; end
    endcase
    return c;
  endfunction

  // DUT A: W=32, ACC_W=8
  logic a_iv, a_ir, a_ov, a_or, a_clr;
  logic [31:0] a_x;
  logic [1:0] a_m, a_ym;
  logic [5:0] a_y;
  logic [7:0] a_acc;
  // DUT B: W=8
  logic b_iv, b_ir, b_ov, b_or, b_clr;
  logic [7:0] b_x;
  logic [1:0] b_m, b_ym;
  logic [3:0] b_y;
  logic [15:0] b_acc;
  // DUT C: W=256
  logic c_iv, c_ir, c_ov, c_or, c_clr;
  logic [255:0] c_x;
  logic [1:0] c_m, c_ym;
  logic [8:0] c_y;
  logic [15:0] c_acc;

  count_bits_pipe #(.W(32), .ACC_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .x(a_x), .mode(a_m),
    .out_valid(a_ov), .out_ready(a_or), .y(a_y), .y_mode(a_ym)
`ifdef COUNT_BITS_PIPE_ACC_EN
    , .acc_clr(a_clr), .acc_r(a_acc)
`endif
  );
  count_bits_pipe #(.W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .x(b_x), .mode(b_m),
    .out_valid(b_ov), .out_ready(b_or), .y(b_y), .y_mode(b_ym)
`ifdef COUNT_BITS_PIPE_ACC_EN
    , .acc_clr(b_clr), .acc_r(b_acc)
`endif
  );
  count_bits_pipe #(.W(256)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .x(c_x), .mode(c_m),
    .out_valid(c_ov), .out_ready(c_or), .y(c_y), .y_mode(c_ym)
`ifdef COUNT_BITS_PIPE_ACC_EN
    , .acc_clr(c_clr), .acc_r(c_acc)
`endif
  );

  exp_t qa[$], qb[$], qc[$];
  logic a_hold = 1'b0, b_hold = 1'b0, c_hold = 1'b0;
  logic [7:0] a_held;
  logic [5:0] b_held;
  logic [10:0] c_held;

  // Scoreboards: inputs sampled at negedge take effect on the next posedge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin qa.delete(); a_hold = 1'b0; end
    else begin
      if (a_hold) chk("A_hold", {a_ov, a_y, a_ym}, {1'b1, a_held});
      if (a_ov && a_or) begin
        if (qa.size() == 0) chk("A_spurious", 1, 0);
        else begin e = qa.pop_front(); chk("A_y", a_y, e.y); chk("A_mode", a_ym, e.m); end
      end
      if (a_iv && a_ir) qa.push_back('{ref_cnt(256'(a_x), 32, int'(a_m)), int'(a_m)});
      a_hold = a_ov && !a_or;
      a_held = {a_y, a_ym};
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin qb.delete(); b_hold = 1'b0; end
    else begin
      if (b_hold) chk("B_hold", {b_ov, b_y, b_ym}, {1'b1, b_held});
      if (b_ov && b_or) begin
        if (qb.size() == 0) chk("B_spurious", 1, 0);
        else begin e = qb.pop_front(); chk("B_y", b_y, e.y); chk("B_mode", b_ym, e.m); end
      end
      if (b_iv && b_ir) qb.push_back('{ref_cnt(256'(b_x), 8, int'(b_m)), int'(b_m)});
      b_hold = b_ov && !b_or;
      b_held = {b_y, b_ym};
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin qc.delete(); c_hold = 1'b0; end
    else begin
      if (c_hold) chk("C_hold", {c_ov, c_y, c_ym}, {1'b1, c_held});
      if (c_ov && c_or) begin
        if (qc.size() == 0) chk("C_spurious", 1, 0);
        else begin e = qc.pop_front(); chk("C_y", c_y, e.y); chk("C_mode", c_ym, e.m); end
      end
      if (c_iv && c_ir) qc.push_back('{ref_cnt(c_x, 256, int'(c_m)), int'(c_m)});
      c_hold = c_ov && !c_or;
      c_held = {c_y, c_ym};
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && (qa.size() + qb.size() + qc.size()) != 0; i++) step();
    chk(tag, qa.size() + qb.size() + qc.size(), 0);
  endtask

  logic [31:0] xs4 [4] = '{32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0};
  int ms4 [4] = '{2, 3, 2, 3};
  int ex4 [4] = '{15, 16, 32, 32};

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    a_iv = 0; a_x = 0; a_m = 0; a_or = 0; a_clr = 0;
    b_iv = 0; b_x = 0; b_m = 0; b_or = 0; b_clr = 0;
    c_iv = 0; c_x = 0; c_m = 0; c_or = 0; c_clr = 0;

    // Reset state
    #2;
    chk("rst_ov", a_ov, 0);
    chk("rst_ir", a_ir, 1);
    chk("rst_y", a_y, 0);
    chk("rst_ym", a_ym, 0);
`ifdef COUNT_BITS_PIPE_ACC_EN
    chk("rst_acc", a_acc, 0);
`endif
    step(2);
    rst_n = 1;

    // Back-to-back zeros count, accepted on the first edge after reset
    a_or = 1; a_iv = 1; a_m = 0; a_x = 32'h0;
    step();
    chk("lat_ov", a_ov, 0);
    a_x = 32'hFFFF_FFFF;
    step();
    chk("y0_ov", a_ov, 1);
    chk("y0", a_y, 32);
    a_x = 32'h0F0F_00FF;
    step();
    chk("y1", a_y, 0);
    a_iv = 0;
    step();
    chk("y2", a_y, 16);
    chk("y2_ov", a_ov, 1);
    step();

    // Leading / trailing zeros
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin a_iv = 1; a_x = xs4[k]; a_m = 2'(ms4[k]); end
      else a_iv = 0;
      step();
      if (k >= 1) begin
        chk("lztz_y", a_y, ex4[k-1]);
        chk("lztz_m", a_ym, ms4[k-1]);
      end
    end
    drain("drain_lztz");

    // Backpressure: two words buffer, then release in order
    a_or = 0; a_iv = 1; a_m = 1;
    for (int i = 0; i < 5; i++) begin
      a_x = (32'h1 << (i + 1)) - 32'h1;
      step();
    end
    chk("bp_ir", a_ir, 0);
    chk("bp_buf", qa.size(), 2);
    chk("bp_ov", a_ov, 1);
    chk("bp_y", a_y, 1);
    a_or = 1;
    step();
    a_iv = 0;
    drain("drain_bp");

    // Reset with two words in flight
    a_or = 0; a_iv = 1; a_m = 0; a_x = 32'h0;
    step();
    a_x = 32'h1;
    step();
    a_iv = 0;
    chk("pre_rst_ov", a_ov, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_ov", a_ov, 0);
    chk("mid_rst_ir", a_ir, 1);
    step();
    rst_n = 1; a_or = 1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin step(); if (a_ov) seen = 1; end
    chk("no_stale", seen, 0);

`ifdef COUNT_BITS_PIPE_ACC_EN
    // Accumulator saturation and clear-on-transfer
    chk("acc_zero", a_acc, 0);
    a_iv = 1; a_m = 0; a_x = 32'h0;
    step(10);
    a_iv = 0;
    drain("drain_acc");
    chk("acc_sat", a_acc, 255);
    a_iv = 1;
    step();
    a_iv = 0;
    step();
    chk("acc_ov", a_ov, 1);
    a_clr = 1;
    step();
    a_clr = 0;
    chk("acc_clr", a_acc, 0);
    a_iv = 1;
    step();
    a_iv = 0;
    drain("drain_acc2");
    chk("acc_after", a_acc, 32);
`endif

    // Random traffic with backpressure on W=8 and W=256
    for (int n = 0; n < 400; n++) begin
      b_iv = ($urandom_range(0, 3) != 0);
      b_or = ($urandom_range(0, 3) != 0);
      b_m  = 2'($urandom);
      b_x  = 8'($urandom);
      c_iv = ($urandom_range(0, 3) != 0);
      c_or = ($urandom_range(0, 3) != 0);
      c_m  = 2'($urandom);
      for (int j = 0; j < 8; j++) c_x[32*j +: 32] = $urandom;
      case ($urandom_range(0, 7))
        0: begin b_x = '0; c_x = '0; end
        1: begin b_x = '1; c_x = '1; end
        default: ;
      endcase
      step();
    end
    b_iv = 0; c_iv = 0; b_or = 1; c_or = 1;
    drain("drain_rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
